// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the game display pipeline.
//   Produces hsync/vsync, the active-video flag, the current pixel coordinates
//   and a one-cycle new_frame tick at the first clock of vertical blanking, so
//   game-state updates land off-screen.
//
// Ports:
//   clk           in   pixel clock
//   rstn          in   synchronous reset, active-low
//   hsync         out  horizontal sync, active level per H_POL
//   vsync         out  vertical sync, active level per V_POL
//   video_active  out  high inside the visible H_ACTIVE x V_ACTIVE window
//   pixel_x       out  horizontal count, 0..H_TOTAL-1
//   pixel_y       out  vertical count, 0..V_TOTAL-1
//   new_frame     out  one-cycle tick at (0, V_ACTIVE)
//   frame_count   out  frames elapsed (only when VT_FRAME_COUNT_EN is defined)
//
// Optional feature: define VT_FRAME_COUNT_EN to add the frame_count port.
//
// Every output is a register loaded from the decode of the *next* counter
// values, so flags and coordinates always describe the same pixel.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
`ifdef VT_FRAME_COUNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        new_frame
);

  localparam int unsigned CW = 16;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          line_end_c;
  logic [CW-1:0] x_next_c;
  logic [CW-1:0] y_next_c;
  logic          hsync_next_c;
  logic          vsync_next_c;
  logic          active_next_c;
  logic          tick_next_c;

  // Next raster position: x wraps every line, y advances on the x wrap.
  always_comb begin
    line_end_c = (pixel_x == H_LAST);
    x_next_c   = pixel_x + CW'(1);
    y_next_c   = pixel_y;
    if (line_end_c) begin
      x_next_c = '0;
      if (pixel_y == V_LAST) begin
        y_next_c = '0;
      end else begin
        y_next_c = pixel_y + CW'(1);
      end
    end
  end

  // Flag decode of the next position, registered alongside the counters.
  always_comb begin
    hsync_next_c  = ~H_POL;
    vsync_next_c  = ~V_POL;
    active_next_c = 1'b0;
    tick_next_c   = 1'b0;
    if ((x_next_c >= HS_START) && (x_next_c < HS_END)) begin
      hsync_next_c = H_POL;
    end
    if ((y_next_c >= VS_START) && (y_next_c < VS_END)) begin
      vsync_next_c = V_POL;
    end
    if ((x_next_c < H_VIS) && (y_next_c < V_VIS)) begin
      active_next_c = 1'b1;
    end
    if ((x_next_c == '0) && (y_next_c == V_VIS)) begin
      tick_next_c = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pixel_x      <= '0;
      pixel_y      <= '0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      video_active <= 1'b0;
      new_frame    <= 1'b0;
    end else begin
      pixel_x      <= x_next_c;
      pixel_y      <= y_next_c;
      hsync        <= hsync_next_c;
      vsync        <= vsync_next_c;
      video_active <= active_next_c;
      new_frame    <= tick_next_c;
    end
  end

`ifdef VT_FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises new_frame; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_count <= '0;
    end else if (tick_next_c) begin
      frame_count <= frame_count + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a reduced raster so several full
// frames fit in a short run. The reference model tracks a single linear
// position within the frame and derives every expected output from it.
module tb_vga_timing;

  localparam int unsigned HA  = 16;
  localparam int unsigned HFP = 3;
  localparam int unsigned HS  = 5;
  localparam int unsigned HBP = 4;
  localparam int unsigned VA  = 10;
  localparam int unsigned VFP = 2;
  localparam int unsigned VS  = 3;
  localparam int unsigned VBP = 2;
  localparam bit          HP  = 1'b1;
  localparam bit          VP  = 1'b0;
  localparam int unsigned HT  = HA + HFP + HS + HBP;
  localparam int unsigned VT  = VA + VFP + VS + VBP;
  localparam int unsigned FT  = HT * VT;

  logic        clk;
  logic        rstn;
  logic        hsync;
  logic        vsync;
  logic        video_active;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        new_frame;
`ifdef VT_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: linear position inside the frame.
  int unsigned m_pos  = 0;
  bit          m_rst  = 1'b1;
  int unsigned m_fc   = 0;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .hsync(hsync),
    .vsync(vsync),
    .video_active(video_active),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
`ifdef VT_FRAME_COUNT_EN
    .frame_count(frame_count),
`endif
    .new_frame(new_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given reset level, then compare every output to the model.
  task automatic step(input logic r);
    int unsigned ex, ey;
    bit ehs, evs, eva, enf;
    rstn = r;
    @(posedge clk);
    if (!r) begin
      m_rst = 1'b1;
      m_fc  = 0;
    end else begin
      m_pos = m_rst ? 1 : (m_pos + 1) % FT;
      m_rst = 1'b0;
      if (m_pos == VA * HT) m_fc = (m_fc + 1) % 65536;
    end
    #1;
    if (m_rst) begin
      ex = 0; ey = 0; ehs = ~HP; evs = ~VP; eva = 1'b0; enf = 1'b0;
    end else begin
      ex  = m_pos % HT;
      ey  = m_pos / HT;
      ehs = (ex >= HA + HFP && ex < HA + HFP + HS) ? HP : ~HP;
      evs = (ey >= VA + VFP && ey < VA + VFP + VS) ? VP : ~VP;
      eva = (ex < HA) && (ey < VA);
      enf = (m_pos == VA * HT);
    end
    chk("pixel_x", 32'(pixel_x), ex);
    chk("pixel_y", 32'(pixel_y), ey);
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("video_active", 32'(video_active), 32'(eva));
    chk("new_frame", 32'(new_frame), 32'(enf));
`ifdef VT_FRAME_COUNT_EN
    chk("frame_count", 32'(frame_count), m_fc);
`endif
  endtask

  initial begin
    int n;
    int gap;
    int hs_cnt;
    int first_hs_x;
    int va_cnt;
    bit seen;
    rstn = 1'b0;

    // Reset held several cycles, then first release edge lands on (1,0).
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    chk("release_x", 32'(pixel_x), 32'd1);
    chk("release_active", 32'(video_active), 32'd1);

    // Two frames: pulse spacing must equal one full frame.
    n = 0; gap = -1; seen = 1'b0;
    for (int i = 0; i < 2 * FT + 10; i++) begin
      step(1'b1);
      n++;
      if (new_frame) begin
        if (seen && gap < 0) gap = n;
        seen = 1'b1;
        n = 0;
        chk("tick_x", 32'(pixel_x), 32'd0);
        chk("tick_y", 32'(pixel_y), 32'(VA));
      end
    end
    chk("tick_spacing", 32'(gap), 32'(FT));

    // One full line from x=0: hsync width and rising position.
    for (int i = 0; i < FT && pixel_x != 16'd0; i++) step(1'b1);
    chk("line_start_x", 32'(pixel_x), 32'd0);
    hs_cnt = 0; first_hs_x = -1;
    for (int i = 0; i < HT; i++) begin
      if (hsync == HP) begin
        hs_cnt++;
        if (first_hs_x < 0) first_hs_x = int'(pixel_x);
      end
      step(1'b1);
    end
    chk("hsync_width", 32'(hs_cnt), 32'(HS));
    chk("hsync_rise_x", 32'(first_hs_x), 32'(HA + HFP));

    // One full frame: active-video cycle count.
    va_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      step(1'b1);
      if (video_active) va_cnt++;
    end
    chk("active_cycles", 32'(va_cnt), 32'(HA * VA));

    // Reset mid-frame: next tick is VA*HT-1 edges after the release edge.
    for (int i = 0; i < FT + 1 && pixel_y != 16'(VA / 2); i++) step(1'b1);
    chk("mid_y", 32'(pixel_y), 32'(VA / 2));
    for (int i = 0; i < 3; i++) step(1'b0);
    step(1'b1);
    n = 0;
    while (!new_frame && n < 2 * FT) begin
      step(1'b1);
      n++;
    end
    chk("post_reset_tick", 32'(n), 32'(VA * HT - 1));

    // Randomised runs interleaved with reset pulses of random length.
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(20, 2 * FT));
      for (int i = 0; i < n; i++) step(1'b1);
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) step(1'b0);
    end
    for (int i = 0; i < FT + 5; i++) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
